// File: rtl/morra_pkg.sv
// Shared types and helpers for the Morra match engine.
//   round_e : result of one judged round
//   game_e  : match outcome
//   state_e : match controller FSM states
//   beats() : cyclic dominance test between two legal moves
package morra_pkg;

    typedef enum logic [1:0] {
        ROUND_NULL = 2'b00,
        ROUND_P1   = 2'b01,
        ROUND_P2   = 2'b10,
        ROUND_TIE  = 2'b11
    } round_e;

    typedef enum logic [1:0] {
        GAME_NONE = 2'b00,
        GAME_P1   = 2'b01,
        GAME_P2   = 2'b10,
        GAME_DRAW = 2'b11
    } game_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // a beats b when the forward cyclic distance a-b lands in the first half
    // of the move circle. Both moves are assumed legal (1..num_moves).
    function automatic logic beats(input int unsigned a, input int unsigned b,
                                   input int unsigned num_moves);
        int unsigned d;
        d = (a + num_moves - b) % num_moves;
        return (d >= 1) && (d <= (num_moves - 1) / 2);
    endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational judge for a single Morra round.
//   a, b        : player 1 / player 2 moves (0 = no move)
//   mem_winner  : previous counted winner (round_e encoding, NULL = none)
//   mem_move    : that winner's winning move
//   round_out   : judged result, round_e encoding
module morra_round_judge
    import morra_pkg::*;
#(
    parameter int NUM_MOVES = 3,
    parameter int MOVE_W    = 2
) (
    input  logic [MOVE_W-1:0] a,
    input  logic [MOVE_W-1:0] b,
    input  logic [1:0]        mem_winner,
    input  logic [MOVE_W-1:0] mem_move,
    output logic [1:0]        round_out
);

    localparam logic [MOVE_W-1:0] MAX_MOVE = MOVE_W'(NUM_MOVES);

    logic illegal;
    logic repeat_hit;

    always_comb begin
        illegal    = (a == '0) || (b == '0) || (a > MAX_MOVE) || (b > MAX_MOVE);
        // Memory is NULL whenever the repeat rule is not in force.
        repeat_hit = ((mem_winner == ROUND_P1) && (a == mem_move)) ||
                     ((mem_winner == ROUND_P2) && (b == mem_move));
        round_out  = ROUND_NULL;
        if (illegal || repeat_hit)
            round_out = ROUND_NULL;
        else if (a == b)
            round_out = ROUND_TIE;
        else if (beats(32'(a), 32'(b), NUM_MOVES))
            round_out = ROUND_P1;
        else
            round_out = ROUND_P2;
    end

endmodule

// File: rtl/morra_match_engine.sv
// Two-player Morra match controller.
// Optional feature macro: MORRA_NO_REPEAT_EN (previous winner may not replay
// their last winning move; without it no memory registers are built).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : (re)start match; {p1,p2} then carry the round budget
//   p1, p2              : player moves
//   move_valid          : a round is offered this cycle
//   move_ready          : high in PLAY; round accepted on move_valid & move_ready
//   round_out/round_valid : registered round result and its 1-cycle strobe
//   game_out/game_done  : match result, done held high in DONE
module morra_match_engine
    import morra_pkg::*;
#(
    parameter int NUM_MOVES  = 3,
    parameter int MOVE_W     = 2,
    parameter int MIN_ROUNDS = 4,
    parameter int LEAD_WIN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MOVE_W-1:0] p1,
    input  logic [MOVE_W-1:0] p2,
    input  logic              move_valid,
    output logic              move_ready,
    output logic [1:0]        round_out,
    output logic              round_valid,
    output logic [1:0]        game_out,
    output logic              game_done
);

    localparam int CW = $clog2(MIN_ROUNDS + 2**(2*MOVE_W)) + 1;
    localparam logic        [CW-1:0] MIN_R    = CW'(MIN_ROUNDS);
    localparam logic signed [CW-1:0] LEAD_POS = CW'(LEAD_WIN);
    localparam logic signed [CW-1:0] LEAD_NEG = -LEAD_POS;

    state_e                  state_reg, state_next;
    logic [CW-1:0]           limit_reg, limit_next;
    logic [CW-1:0]           played_reg, played_next;
    logic signed [CW-1:0]    lead_reg, lead_next;
    logic [1:0]              round_out_reg, round_out_next;
    logic                    round_valid_reg, round_valid_next;
    logic [1:0]              game_out_reg, game_out_next;
    logic                    game_done_reg, game_done_next;

    logic [1:0]              mem_winner_reg;
    logic [MOVE_W-1:0]       mem_move_reg;

    logic                    accept;
    logic [1:0]              judged;
    logic                    counted;
    logic [CW-1:0]           played_new;
    logic signed [CW-1:0]    lead_new;
    logic                    end_hit;

    assign move_ready = (state_reg == ST_PLAY);
    // start has priority, so a coincident move is never taken.
    assign accept     = move_ready && move_valid && !start;

    morra_round_judge #(
        .NUM_MOVES (NUM_MOVES),
        .MOVE_W    (MOVE_W)
    ) u_judge (
        .a          (p1),
        .b          (p2),
        .mem_winner (mem_winner_reg),
        .mem_move   (mem_move_reg),
        .round_out  (judged)
    );

    always_comb begin
        counted    = (judged != ROUND_NULL);
        played_new = played_reg + CW'(1);
        lead_new   = lead_reg;
        if (judged == ROUND_P1)
            lead_new = lead_reg + CW'(1);
        else if (judged == ROUND_P2)
            lead_new = lead_reg - CW'(1);
        end_hit = ((played_new >= MIN_R) && ((lead_new >= LEAD_POS) || (lead_new <= LEAD_NEG)))
                  || (played_new == limit_reg);
    end

`ifdef MORRA_NO_REPEAT_EN
    logic [1:0]        mem_winner_next;
    logic [MOVE_W-1:0] mem_move_next;

    always_comb begin
        mem_winner_next = mem_winner_reg;
        mem_move_next   = mem_move_reg;
        if (start) begin
            mem_winner_next = ROUND_NULL;
            mem_move_next   = '0;
        end else if (accept) begin
            if (judged == ROUND_TIE) begin
                mem_winner_next = ROUND_NULL;
                mem_move_next   = '0;
            end else if (judged == ROUND_P1) begin
                mem_winner_next = ROUND_P1;
                mem_move_next   = p1;
            end else if (judged == ROUND_P2) begin
                mem_winner_next = ROUND_P2;
                mem_move_next   = p2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_winner_reg <= ROUND_NULL;
            mem_move_reg   <= '0;
        end else begin
            mem_winner_reg <= mem_winner_next;
            mem_move_reg   <= mem_move_next;
        end
    end
`else
    assign mem_winner_reg = ROUND_NULL;
    assign mem_move_reg   = '0;
`endif

    always_comb begin
        state_next       = state_reg;
        limit_next       = limit_reg;
        played_next      = played_reg;
        lead_next        = lead_reg;
        round_out_next   = round_out_reg;
        round_valid_next = 1'b0;
        game_out_next    = game_out_reg;
        game_done_next   = game_done_reg;
        if (start) begin
            state_next     = ST_PLAY;
            limit_next     = MIN_R + CW'({p1, p2});
            played_next    = '0;
            lead_next      = '0;
            round_out_next = ROUND_NULL;
            game_out_next  = GAME_NONE;
            game_done_next = 1'b0;
        end else if (accept) begin
            round_out_next   = judged;
            round_valid_next = 1'b1;
            if (counted) begin
                played_next = played_new;
                lead_next   = lead_new;
                if (end_hit) begin
                    if (lead_new > 0)
                        game_out_next = GAME_P1;
                    else if (lead_new < 0)
                        game_out_next = GAME_P2;
                    else
                        game_out_next = GAME_DRAW;
                    game_done_next = 1'b1;
                    state_next     = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            limit_reg       <= '0;
            played_reg      <= '0;
            lead_reg        <= '0;
            round_out_reg   <= ROUND_NULL;
            round_valid_reg <= 1'b0;
            game_out_reg    <= GAME_NONE;
            game_done_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            limit_reg       <= limit_next;
            played_reg      <= played_next;
            lead_reg        <= lead_next;
            round_out_reg   <= round_out_next;
            round_valid_reg <= round_valid_next;
            game_out_reg    <= game_out_next;
            game_done_reg   <= game_done_next;
        end
    end

    assign round_out   = round_out_reg;
    assign round_valid = round_valid_reg;
    assign game_out    = game_out_reg;
    assign game_done   = game_done_reg;

endmodule

// File: tb/tb_morra_match_engine.sv
// Scoreboard bench for morra_match_engine (default parameters).
// Honours MORRA_NO_REPEAT_EN in its reference model.
module tb_morra_match_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] p1 = 2'd0;
    logic [1:0] p2 = 2'd0;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic [1:0] round_out;
    logic       round_valid;
    logic [1:0] game_out;
    logic       game_done;

`ifdef MORRA_NO_REPEAT_EN
    localparam bit NO_REPEAT = 1'b1;
`else
    localparam bit NO_REPEAT = 1'b0;
`endif

    morra_match_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .p1          (p1),
        .p2          (p2),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .round_out   (round_out),
        .round_valid (round_valid),
        .game_out    (game_out),
        .game_done   (game_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rounds = 0;

    // Reference model state: 0 idle, 1 play, 2 done
    int m_state = 0;
    int m_limit = 0;
    int m_played = 0;
    int m_lead = 0;
    int m_mw = 0;
    int m_mm = 0;

    logic [4:0] sb_q[$];   // {round_out, game_out, game_done}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] model_judge(input int a, input int b);
        if (a < 1 || a > 3 || b < 1 || b > 3) return 2'b00;
        if (NO_REPEAT && ((m_mw == 1 && a == m_mm) || (m_mw == 2 && b == m_mm))) return 2'b00;
        if (a == b) return 2'b11;
        if (((a - b + 3) % 3) == 1) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_reset();
        m_state = 0; m_limit = 0; m_played = 0; m_lead = 0; m_mw = 0; m_mm = 0;
    endtask

    task automatic drive_round(input int a, input int b);
        logic [1:0] r;
        logic [1:0] g;
        logic       d;
        @(negedge clk);
        start = 1'b0;
        p1 = 2'(a);
        p2 = 2'(b);
        move_valid = 1'b1;
        if (m_state == 1) begin
            r = model_judge(a, b);
            g = 2'b00;
            d = 1'b0;
            if (r != 2'b00) begin
                m_played++;
                if (r == 2'b01) begin m_lead++; m_mw = 1; m_mm = a; end
                else if (r == 2'b10) begin m_lead--; m_mw = 2; m_mm = b; end
                else begin m_mw = 0; m_mm = 0; end
                if ((m_played >= 4 && (m_lead >= 2 || m_lead <= -2)) || m_played == m_limit) begin
                    g = (m_lead > 0) ? 2'b01 : ((m_lead < 0) ? 2'b10 : 2'b11);
                    d = 1'b1;
                    m_state = 2;
                end
            end
            sb_q.push_back({r, g, d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            move_valid = 1'b0;
        end
    endtask

    task automatic start_match(input int budget, input bit with_move);
        logic [3:0] bw;
        @(negedge clk);
        bw = 4'(budget);
        start = 1'b1;
        p1 = bw[3:2];
        p2 = bw[1:0];
        move_valid = with_move;
        m_state = 1; m_limit = 4 + budget; m_played = 0; m_lead = 0; m_mw = 0; m_mm = 0;
        @(negedge clk);
        start = 1'b0;
        move_valid = 1'b0;
    endtask

    // Scoreboard monitor: every round_valid must match the oldest expectation.
    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (round_valid) begin
            n_rounds++;
            $display("round %0d: round_out=%b game_out=%b game_done=%b", n_rounds, round_out, game_out, game_done);
            if (sb_q.size() == 0) begin
                check("unexpected_round_valid", 32'(round_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("round_out", 32'(round_out), 32'(e[4:3]));
                check("game_out", 32'(game_out), 32'(e[2:1]));
                check("game_done", 32'(game_done), 32'(e[0]));
            end
        end
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_round_valid", 32'(round_valid), 32'd0);
        check("rst_round_out", 32'(round_out), 32'd0);
        check("rst_game", 32'({game_out, game_done}), 32'd0);
        check("rst_ready", 32'(move_ready), 32'd0);
        rst = 1'b0;
        drive_round(1, 3);          // IDLE: dropped
        idle(2);

        // 1: P1 wins every round, lead ends match at round 4
        start_match(0, 1'b0);
        check("play_ready", 32'(move_ready), 32'd1);
        drive_round(1, 3); drive_round(2, 1); drive_round(3, 2); drive_round(1, 3);
        idle(2);
        check("t1_done", 32'({game_out, game_done}), 32'b011);
        check("done_ready", 32'(move_ready), 32'd0);

        // 2: four ties reach the limit as a draw
        start_match(0, 1'b0);
        check("restart_clears", 32'({game_out, game_done}), 32'd0);
        drive_round(1, 1); drive_round(2, 2); drive_round(3, 3); drive_round(1, 1);
        idle(2);
        check("t2_done", 32'({game_out, game_done}), 32'b111);

        // 3: repeat rule (model-selected result), then ties to finish
        start_match(0, 1'b0);
        drive_round(2, 1); drive_round(2, 3);
        for (int i = 0; i < 6; i++) drive_round(1, 1);
        idle(2);

        // 4: null moves do not count; move_valid in DONE is dropped
        start_match(0, 1'b0);
        drive_round(0, 2); drive_round(1, 0); drive_round(0, 0);
        drive_round(1, 1); drive_round(2, 2); drive_round(3, 3);
        idle(1);
        check("t4_not_done", 32'(game_done), 32'd0);
        drive_round(1, 1);
        drive_round(1, 2); drive_round(2, 1);   // DONE: dropped
        idle(2);
        check("t4_done", 32'({game_out, game_done}), 32'b111);

        // 5: budget 15 -> limit 19, tie then alternating wins, draw at 19
        start_match(15, 1'b0);
        drive_round(1, 1);
        for (int i = 0; i < 9; i++) begin
            drive_round(2, 1);
            drive_round(1, 2);
        end
        idle(1);
        check("t5_done", 32'({game_out, game_done}), 32'b111);
        drive_round(2, 1);                       // DONE: dropped
        idle(2);

        // 6: reset mid-match, then start coincident with a move
        start_match(0, 1'b0);
        drive_round(1, 3);
        drive_round(2, 1);
        @(negedge clk);
        move_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({round_out, round_valid, game_out, game_done, move_ready}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        move_valid = 1'b0;
        start_match(0, 1'b1);                    // coincident move discarded
        idle(1);
        drive_round(1, 1); drive_round(2, 2); drive_round(3, 3);
        idle(1);
        check("t6_not_done", 32'(game_done), 32'd0);
        drive_round(1, 1);
        idle(3);
        check("t6_done", 32'({game_out, game_done}), 32'b111);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
